// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the multi-channel memory arbiter.
package mem_arb_pkg;

  // Two-state transaction controller: waiting for a requester, or holding
  // one memory access open until it completes.
  typedef enum logic {
    MEM_ARB_IDLE = 1'b0,
    MEM_ARB_BUSY = 1'b1
  } type_mem_arb_states_e;

  // Values for the ARB_MODE parameter.
  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

endpackage : mem_arb_pkg

// File: rtl/arb_pick.sv
// Combinational winner selection for the memory arbiter.
// Fixed mode picks the lowest-index requester; round-robin mode starts the
// search one past the pointer and wraps modulo NUM_CH.
module arb_pick #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  input  logic              mode_rr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [PTR_W-1:0]  idx_o
);

  logic found;
  int   cand;

  // Walk the candidates in priority order and take the first requester.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = mode_rr_i ? ((int'(ptr_i) + 1 + k) % NUM_CH) : k;
      if (!found && req_i[cand[PTR_W-1:0]]) begin
        found                      = 1'b1;
        grant_o[cand[PTR_W-1:0]]   = 1'b1;
        idx_o                      = cand[PTR_W-1:0];
      end
    end
  end

endmodule : arb_pick

// File: rtl/mem_arbiter_nch.sv
// N-channel arbiter in front of a single main-memory port.
// One transaction at a time: a winner is chosen in IDLE, its request is
// latched and presented to memory in BUSY until mem_ack_i (or a timeout)
// completes it, then the controller idles for one cycle before re-arbitrating.
// Optional build macro: MEM_ARB_TIMEOUT_EN enables the BUSY-cycle watchdog
// that completes a stuck access with an error after TIMEOUT_CYC cycles.
import mem_arb_pkg::*;

module mem_arbiter_nch #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 128,
  parameter int ARB_MODE    = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_req_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
  input  logic [NUM_CH-1:0]        ch_wen_i,
  output logic [NUM_CH-1:0]        ch_ack_o,
  output logic [NUM_CH*DATA_W-1:0] ch_rdata_o,
  output logic [NUM_CH-1:0]        ch_err_o,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  output logic                     mem_wen_o,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  input  logic                     mem_ack_i,
  output logic [NUM_CH-1:0]        grant_o
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  type_mem_arb_states_e state_q;
  logic [NUM_CH-1:0]    grant_q;
  logic [PTR_W-1:0]     gidx_q;
  logic [PTR_W-1:0]     rr_ptr_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic                 wen_q;

  logic [NUM_CH-1:0]    pick_grant;
  logic [PTR_W-1:0]     pick_idx;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 sel_wen;

  logic                 busy;
  logic                 done_ack;
  logic                 timeout_hit;
  logic                 done;

  arb_pick #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arb_pick (
    .req_i     (ch_req_i),
    .ptr_i     (rr_ptr_q),
    .mode_rr_i (ARB_MODE == ARB_MODE_RR),
    .grant_o   (pick_grant),
    .idx_o     (pick_idx)
  );

  // Route the winning channel's address, data and write enable to the latches.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_grant[i]) begin
        sel_addr  = ch_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = ch_wdata_i[i*DATA_W +: DATA_W];
      end
    end
    sel_wen = |(pick_grant & ch_wen_i);
  end

  assign busy     = (state_q == MEM_ARB_BUSY);
  assign done_ack = busy && mem_ack_i;
  assign done     = done_ack || timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q;

  // The counter reads 0 in the first BUSY cycle, so TIMEOUT_CYC-1 marks the
  // last cycle the access is allowed to stay open.
  assign timeout_hit = busy && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  // Transaction controller: arbitration, request latching, completion and
  // round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the request latches are plain registers, not a memory, so they
      // are reset along with the control state and never leak stale data.
      state_q  <= MEM_ARB_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= PTR_W'(NUM_CH - 1);
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values regardless of statement order.
      case (state_q)
        MEM_ARB_IDLE: begin
          if (|ch_req_i) begin
            state_q <= MEM_ARB_BUSY;
            grant_q <= pick_grant;
            gidx_q  <= pick_idx;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            wen_q   <= sel_wen;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        MEM_ARB_BUSY: begin
          if (done) begin
            state_q  <= MEM_ARB_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= gidx_q;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end else begin
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        default: begin
          state_q <= MEM_ARB_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // Completion response: ack (with read data) wins over a coinciding timeout.
  always_comb begin
    ch_ack_o   = '0;
    ch_err_o   = '0;
    ch_rdata_o = '0;
    if (done_ack) begin
      ch_ack_o = grant_q;
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant_q[i]) begin
          ch_rdata_o[i*DATA_W +: DATA_W] = mem_rdata_i;
        end
      end
    end else if (timeout_hit) begin
      ch_ack_o = grant_q;
      ch_err_o = grant_q;
    end
  end

  assign grant_o     = grant_q;
  assign mem_req_o   = busy;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wen_o   = wen_q;

endmodule : mem_arbiter_nch

// File: tb/tb_mem_arbiter_nch.sv
// Self-checking bench for mem_arbiter_nch. Two instances, one round-robin and
// one fixed-priority, see identical stimulus; a high-level model predicts the
// winner of each transaction from the request vector alone.
// Build with MEM_ARB_TIMEOUT_EN defined to add the watchdog scenarios.
module tb_mem_arbiter_nch;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    ch_req_i;
  logic [N*AW-1:0] ch_addr_i;
  logic [N*DW-1:0] ch_wdata_i;
  logic [N-1:0]    ch_wen_i;
  logic [DW-1:0]   mem_rdata_i;
  logic            mem_ack_i;

  logic [N-1:0]    ack_rr, err_rr, grant_rr;
  logic [N*DW-1:0] rdata_rr;
  logic            mreq_rr, mwen_rr;
  logic [AW-1:0]   maddr_rr;
  logic [DW-1:0]   mwdata_rr;

  logic [N-1:0]    ack_fx, err_fx, grant_fx;
  logic [N*DW-1:0] rdata_fx;
  logic            mreq_fx, mwen_fx;
  logic [AW-1:0]   maddr_fx;
  logic [DW-1:0]   mwdata_fx;

  int errors = 0;
  int checks = 0;
  int last_rr = N - 1;   // model: channel granted most recently (RR instance)

  always #5 clk = ~clk;

  mem_arbiter_nch #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT_CYC(16)
  ) dut_rr (
    .clk(clk), .rst_n(rst_n), .ch_req_i(ch_req_i), .ch_addr_i(ch_addr_i),
    .ch_wdata_i(ch_wdata_i), .ch_wen_i(ch_wen_i), .ch_ack_o(ack_rr),
    .ch_rdata_o(rdata_rr), .ch_err_o(err_rr), .mem_req_o(mreq_rr),
    .mem_addr_o(maddr_rr), .mem_wdata_o(mwdata_rr), .mem_wen_o(mwen_rr),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .grant_o(grant_rr)
  );

  mem_arbiter_nch #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT_CYC(16)
  ) dut_fx (
    .clk(clk), .rst_n(rst_n), .ch_req_i(ch_req_i), .ch_addr_i(ch_addr_i),
    .ch_wdata_i(ch_wdata_i), .ch_wen_i(ch_wen_i), .ch_ack_o(ack_fx),
    .ch_rdata_o(rdata_fx), .ch_err_o(err_fx), .mem_req_o(mreq_fx),
    .mem_addr_o(maddr_fx), .mem_wdata_o(mwdata_fx), .mem_wen_o(mwen_fx),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .grant_o(grant_fx)
  );

  task automatic check(input string tag, input logic [N*DW-1:0] obs,
                       input logic [N*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first requester strictly after the last grant.
  function automatic int model_rr(input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(last_rr + k) % N]) return (last_rr + k) % N;
    end
    return -1;
  endfunction

  // Fixed-priority reference: lowest-index requester.
  function automatic int model_fx(input logic [N-1:0] req);
    for (int k = 0; k < N; k++) begin
      if (req[k]) return k;
    end
    return -1;
  endfunction

  task automatic randomize_channels();
    for (int i = 0; i < N; i++) begin
      ch_addr_i[i*AW +: AW]  = $urandom;
      ch_wdata_i[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
    end
    ch_wen_i = N'($urandom);
  endtask

  // One complete transaction starting from an IDLE negedge; mem_ack_i is
  // raised in BUSY cycle delay+1. Optionally scrambles all channel inputs
  // during BUSY to show the latched request is unaffected.
  task automatic do_txn(input logic [N-1:0] req, input int delay, input bit scramble);
    int            wr, wf;
    logic [AW-1:0] ea_r, ea_f;
    logic [DW-1:0] ed_r, ed_f, rd;
    logic          ew_r, ew_f;
    logic [N-1:0]  oh_r, oh_f;
    logic [N*DW-1:0] er_r, er_f;
    ch_req_i = req;
    #1;
    check("idle_grant_rr", grant_rr, '0);
    check("idle_mreq_rr", mreq_rr, '0);
    check("idle_grant_fx", grant_fx, '0);
    wr = model_rr(req);
    wf = model_fx(req);
    oh_r = N'(1) << wr;
    oh_f = N'(1) << wf;
    ea_r = ch_addr_i[wr*AW +: AW];
    ea_f = ch_addr_i[wf*AW +: AW];
    ed_r = ch_wdata_i[wr*DW +: DW];
    ed_f = ch_wdata_i[wf*DW +: DW];
    ew_r = ch_wen_i[wr];
    ew_f = ch_wen_i[wf];
    @(negedge clk);
    check("busy_grant_rr", grant_rr, oh_r);
    check("busy_grant_fx", grant_fx, oh_f);
    check("busy_mreq_rr", mreq_rr, 1'b1);
    check("busy_mreq_fx", mreq_fx, 1'b1);
    check("busy_wdata_rr", mwdata_rr, ed_r);
    check("busy_wdata_fx", mwdata_fx, ed_f);
    for (int c = 0; c < delay; c++) begin
      if (scramble) begin
        randomize_channels();
        ch_req_i = N'($urandom);
      end
      #1;
      check("wait_ack_rr", ack_rr, '0);
      check("wait_addr_rr", maddr_rr, ea_r);
      check("wait_addr_fx", maddr_fx, ea_f);
      check("wait_wen_rr", mwen_rr, ew_r);
      check("wait_mreq_rr", mreq_rr, 1'b1);
      @(negedge clk);
    end
    rd = {$urandom, $urandom, $urandom, $urandom};
    mem_rdata_i = rd;
    mem_ack_i   = 1'b1;
    er_r = '0;
    er_r[wr*DW +: DW] = rd;
    er_f = '0;
    er_f[wf*DW +: DW] = rd;
    #1;
    check("done_ack_rr", ack_rr, oh_r);
    check("done_ack_fx", ack_fx, oh_f);
    check("done_rdata_rr", rdata_rr, er_r);
    check("done_rdata_fx", rdata_fx, er_f);
    check("done_err_rr", err_rr, '0);
    check("done_addr_rr", maddr_rr, ea_r);
    check("done_wen_fx", mwen_fx, ew_f);
    @(negedge clk);
    mem_ack_i = 1'b0;
    last_rr   = wr;
  endtask

  // Hard bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pending_ch;
    logic [N-1:0] rq;
    rst_n       = 1'b0;
    ch_req_i    = '0;
    ch_addr_i   = '0;
    ch_wdata_i  = '0;
    ch_wen_i    = '0;
    mem_rdata_i = '0;
    mem_ack_i   = 1'b0;
    #1;
    check("rst_grant", grant_rr, '0);
    check("rst_mreq", mreq_rr, '0);
    check("rst_addr", maddr_rr, '0);
    check("rst_ack", ack_rr, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All four channels requesting, ack 3 cycles after mem_req_o rises:
    // round-robin visits 0,1,2,3,0; fixed always picks 0.
    randomize_channels();
    for (int t = 0; t < 5; t++) do_txn(4'b1111, 3, 1'b0);

    // Channels 1 and 3 requesting: fixed mode never reaches channel 3.
    for (int t = 0; t < 3; t++) do_txn(4'b1010, 2, 1'b0);

    // Channel 2 write; channel inputs and requests scrambled while BUSY.
    randomize_channels();
    ch_addr_i[2*AW +: AW]  = 32'h8000_0040;
    ch_wdata_i[2*DW +: DW] = {16{8'hA5}};
    ch_wen_i[2]            = 1'b1;
    do_txn(4'b0100, 4, 1'b1);

    // A stray ack with nothing in flight does nothing.
    ch_req_i  = '0;
    mem_ack_i = 1'b1;
    #1;
    check("stray_ack_rr", ack_rr, '0);
    check("stray_ack_fx", ack_fx, '0);
    @(negedge clk);
    check("stray_mreq", mreq_rr, '0);
    check("stray_grant", grant_rr, '0);
    mem_ack_i = 1'b0;

    // Randomized traffic.
    for (int t = 0; t < 20; t++) begin
      randomize_channels();
      rq = N'($urandom_range(1, 15));
      do_txn(rq, int'($urandom_range(0, 5)), 1'($urandom));
    end

    // Reset in BUSY cycle 2 of a channel-3 access, with the pointer at 0.
    do_txn(4'b0001, 1, 1'b0);
    ch_req_i = 4'b1000;
    @(negedge clk);
    check("pre_rst_grant", grant_rr, 4'b1000);
    @(negedge clk);
    rst_n     = 1'b0;
    mem_ack_i = 1'b1;
    #1;
    check("inrst_ack_rr", ack_rr, '0);
    check("inrst_ack_fx", ack_fx, '0);
    check("inrst_mreq", mreq_rr, '0);
    check("inrst_grant", grant_rr, '0);
    check("inrst_addr", maddr_rr, '0);
    check("inrst_wdata", mwdata_rr, '0);
    check("inrst_wen", mwen_rr, '0);
    check("inrst_rdata", rdata_rr, '0);
    check("inrst_err", err_rr, '0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ack_i = 1'b0;
    last_rr   = N - 1;
    // Pointer back at NUM_CH-1: channel 0 wins first, then channel 3 alone.
    do_txn(4'b1111, 1, 1'b0);
    do_txn(4'b1000, 2, 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
    // No ack: error completion in BUSY cycle 16, then a stray ack is ignored.
    randomize_channels();
    ch_req_i = 4'b0100;
    pending_ch = model_rr(4'b0100);
    @(negedge clk);
    for (int c = 1; c < 16; c++) begin
      #1;
      check("to_wait_ack", ack_rr, '0);
      @(negedge clk);
    end
    #1;
    check("to_ack_rr", ack_rr, N'(1) << pending_ch);
    check("to_err_rr", err_rr, N'(1) << pending_ch);
    check("to_err_fx", err_fx, 4'b0100);
    check("to_rdata", rdata_rr, '0);
    ch_req_i = '0;
    @(negedge clk);
    last_rr = pending_ch;
    check("to_drop_mreq", mreq_rr, '0);
    mem_ack_i = 1'b1;
    #1;
    check("to_stray_ack", ack_rr, '0);
    @(negedge clk);
    mem_ack_i = 1'b0;
    check("to_stray_mreq", mreq_rr, '0);
    // Ack in the same cycle as the timeout: ack wins, no error.
    do_txn(4'b0001, 15, 1'b0);
`else
    pending_ch = 0;
    check("no_timeout_err", err_rr | err_fx, '0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_arbiter_nch

// File: doc/mem_arbiter_nch.md
MEM_ARBITER_NCH -- requirements
Module: mem_arbiter_nch

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of requester channels (2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-003 SHALL have parameter DATA_W, default 128, read/write data width (one cache line).
REQ-004 SHALL have parameter ARB_MODE, default 1, arbitration policy: 0 fixed priority, 1 round-robin.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024, busy-cycle limit; used only when MEM_ARB_TIMEOUT_EN is defined.
REQ-006 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port ch_req_i, input, NUM_CH, per-channel request.
REQ-009 SHALL have port ch_addr_i, input, NUM_CH*ADDR_W, per-channel address; channel i at slice [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port ch_wdata_i, input, NUM_CH*DATA_W, per-channel write data; same slicing as ch_addr_i.
REQ-011 SHALL have port ch_wen_i, input, NUM_CH, per-channel write enable.
REQ-012 SHALL have port ch_ack_o, output, NUM_CH, per-channel completion pulse.
REQ-013 SHALL have port ch_rdata_o, output, NUM_CH*DATA_W, per-channel read data.
REQ-014 SHALL have port ch_err_o, output, NUM_CH, per-channel error flag, valid with ch_ack_o.
REQ-015 SHALL have port mem_req_o, output, 1, request to main memory.
REQ-016 SHALL have port mem_addr_o, output, ADDR_W, address to main memory.
REQ-017 SHALL have port mem_wdata_o, output, DATA_W, write data to main memory.
REQ-018 SHALL have port mem_wen_o, output, 1, write enable to main memory.
REQ-019 SHALL have port mem_rdata_i, input, DATA_W, read data from main memory.
REQ-020 SHALL have port mem_ack_i, input, 1, completion from main memory.
REQ-021 SHALL have port grant_o, output, NUM_CH, one-hot registered grant; all zero when idle.

Function
REQ-022 SHALL implement states MEM_ARB_IDLE and MEM_ARB_BUSY.
REQ-023 IDLE, any ch_req_i set: SHALL pick a winner, register grant_o, latch the winner's addr/wdata/wen, and enter BUSY on the next edge; mem_req_o rises 1 cycle after the request is first seen.
REQ-024 Fixed mode SHALL grant the lowest-index requester; round-robin mode SHALL search from last-granted+1, wrapping modulo NUM_CH.
REQ-025 BUSY SHALL hold mem_req_o=1 and drive mem_addr_o/mem_wdata_o/mem_wen_o from the latched values, independent of later ch_* changes.
REQ-026 BUSY with mem_ack_i=1 SHALL combinationally pulse ch_ack_o[g]=1 and drive ch_rdata_o slice g = mem_rdata_i, then return to IDLE; all other ch_rdata_o slices SHALL be 0.
REQ-027 The round-robin pointer SHALL update to g only on completion (ack or timeout).
REQ-028 A new arbitration SHALL occur no earlier than the cycle after completion, giving a 1-cycle IDLE gap between back-to-back transactions.
REQ-029 mem_ack_i received in IDLE SHALL be ignored.
REQ-030 ch_req_i deasserted by the granted channel while BUSY SHALL NOT abort the transaction.

Reset
REQ-031 On rst_n low, SHALL asynchronously enter IDLE; grant_o, latches and timeout counter SHALL be 0, and the RR pointer SHALL be NUM_CH-1 (channel 0 wins first).
REQ-032 A transaction in flight at reset SHALL be discarded with no ch_ack_o; mem_req_o and all outputs SHALL be 0 during reset.

Configuration
REQ-033 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL count BUSY cycles; at TIMEOUT_CYC cycles without ack, SHALL pulse ch_ack_o[g]=1 and ch_err_o[g]=1 with rdata 0, drop mem_req_o, and return to IDLE.
REQ-034 When ack and timeout coincide, ack SHALL win and ch_err_o SHALL be 0.
REQ-035 Without MEM_ARB_TIMEOUT_EN, SHALL omit the counter and tie ch_err_o to 0; the port list SHALL be unchanged.

Structure
REQ-036 Package mem_arb_pkg SHALL hold type_mem_arb_states_e and constants ARB_MODE_FIXED=0 and ARB_MODE_RR=1.
REQ-037 Winner selection SHALL be a combinational sub-module arb_pick (request vector, pointer, mode -> one-hot winner).

Verification
REQ-038 NUM_CH=4, RR, ch_req_i=4'b1111 held, mem_ack_i 3 cycles after each mem_req_o -> grants in order 0,1,2,3,0, 1 idle cycle between grants.
REQ-039 Fixed mode, ch_req_i=4'b1010 held -> channel 1 granted on every transaction; channel 3 never granted.
REQ-040 ch 2 write, addr 0x8000_0040, wdata 0xA5 pattern, then ch_addr_i changed during BUSY -> mem_addr_o stays 0x8000_0040, mem_wen_o=1 until ack.
REQ-041 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, no mem_ack_i -> ch_ack_o[g] and ch_err_o[g] pulse at BUSY cycle 16; a later stray mem_ack_i is ignored.
REQ-042 rst_n low at BUSY cycle 2 of ch 3 -> outputs 0, no ack; after release with ch_req_i=4'b1000 -> ch 3 regranted, RR pointer reset.
